// File: rtl/ram_march_tester.sv
// Built-in self-test controller for a 16x8 single-port synchronous RAM.
// Two-phase write/read-back pattern test (P(a) then ~P(a)) with first-failure capture.
module ram_march_tester #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] seed,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW+1:0] err_cnt,
  output logic [AW-1:0] first_err_addr,
  output logic [DW-1:0] first_err_exp,
  output logic [DW-1:0] first_err_act,
  output logic          first_err_phase,
  output logic          ram_wr,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic [2:0]    dbg_state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [AW-1:0] LAST_ADDR = '1;
  localparam logic [AW+1:0] ERR_MAX   = '1;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          phase_q, phase_d;
  logic [DW-1:0] seed_q, seed_d;
  logic          ram_wr_q, ram_wr_d;
  logic [DW-1:0] ram_din_q, ram_din_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [AW+1:0] err_cnt_q, err_cnt_d;
  logic [AW-1:0] fe_addr_q, fe_addr_d;
  logic [DW-1:0] fe_exp_q, fe_exp_d;
  logic [DW-1:0] fe_act_q, fe_act_d;
  logic          fe_phase_q, fe_phase_d;
  logic          pipe_vld_q, pipe_vld_d;
  logic [AW-1:0] pipe_addr_q, pipe_addr_d;
  logic [DW-1:0] pipe_exp_q, pipe_exp_d;

  function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a, input logic [DW-1:0] s,
                                            input logic ph);
    logic [DW-1:0] p;
    p = DW'(a) ^ s;
    return ph ? ~p : p;
  endfunction

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    phase_d     = phase_q;
    seed_d      = seed_q;
    ram_wr_d    = 1'b0;
    ram_din_d   = '0;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_cnt_d   = err_cnt_q;
    fe_addr_d   = fe_addr_q;
    fe_exp_d    = fe_exp_q;
    fe_act_d    = fe_act_q;
    fe_phase_d  = fe_phase_q;
    pipe_vld_d  = 1'b0;
    pipe_addr_d = pipe_addr_q;
    pipe_exp_d  = pipe_exp_q;

    // Read data returns one cycle after its issue cycle; compare against the delayed expectation.
    if (pipe_vld_q && (ram_dout != pipe_exp_q)) begin
      if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + 1'b1;
      if (err_cnt_q == '0) begin
        fe_addr_d  = pipe_addr_q;
        fe_exp_d   = pipe_exp_q;
        fe_act_d   = ram_dout;
        fe_phase_d = phase_q;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          seed_d     = seed;
          phase_d    = 1'b0;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          err_cnt_d  = '0;
          fe_addr_d  = '0;
          fe_exp_d   = '0;
          fe_act_d   = '0;
          fe_phase_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = S_WRITE;
          addr_d     = '0;
          ram_wr_d   = 1'b1;
          ram_din_d  = pattern('0, seed, 1'b0);
        end
      end
      S_WRITE: begin
        if (addr_q == LAST_ADDR) begin
          state_d = S_READ;
          addr_d  = '0;
        end else begin
          addr_d    = addr_q + 1'b1;
          ram_wr_d  = 1'b1;
          ram_din_d = pattern(addr_q + 1'b1, seed_q, phase_q);
        end
      end
      S_READ: begin
        pipe_vld_d  = 1'b1;
        pipe_addr_d = addr_q;
        pipe_exp_d  = pattern(addr_q, seed_q, phase_q);
        if (addr_q == LAST_ADDR) state_d = S_DRAIN;
        else addr_d = addr_q + 1'b1;
      end
      S_DRAIN: begin
        addr_d = '0;
        if (!phase_q) begin
          phase_d   = 1'b1;
          state_d   = S_WRITE;
          ram_wr_d  = 1'b1;
          ram_din_d = pattern('0, seed_q, 1'b1);
        end else begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_cnt_d == '0);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        addr_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      phase_q     <= 1'b0;
      seed_q      <= '0;
      ram_wr_q    <= 1'b0;
      ram_din_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= '0;
      fe_addr_q   <= '0;
      fe_exp_q    <= '0;
      fe_act_q    <= '0;
      fe_phase_q  <= 1'b0;
      pipe_vld_q  <= 1'b0;
      pipe_addr_q <= '0;
      pipe_exp_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      phase_q     <= phase_d;
      seed_q      <= seed_d;
      ram_wr_q    <= ram_wr_d;
      ram_din_q   <= ram_din_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_cnt_q   <= err_cnt_d;
      fe_addr_q   <= fe_addr_d;
      fe_exp_q    <= fe_exp_d;
      fe_act_q    <= fe_act_d;
      fe_phase_q  <= fe_phase_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_addr_q <= pipe_addr_d;
      pipe_exp_q  <= pipe_exp_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_cnt         = err_cnt_q;
  assign first_err_addr  = fe_addr_q;
  assign first_err_exp   = fe_exp_q;
  assign first_err_act   = fe_act_q;
  assign first_err_phase = fe_phase_q;
  assign ram_wr          = ram_wr_q;
  assign ram_addr        = addr_q;
  assign ram_din         = ram_din_q;
  assign dbg_state       = state_q;

endmodule

// File: doc/ram_march_tester.md
Name: ram_march_tester

Overview:
- Initiator for the 16x8 single-port synchronous RAM: drives its clk-domain wr/addr/din and captures its registered dout.
- Performs a two-phase write/read-back pattern test and reports pass/fail with first-failure diagnostics.
- Sits beside the RAM as a built-in self-test controller.
- Doubles as the stimulus engine for RAM bring-up.

Parameters:
- DW, 8, data width; matches the RAM word.
- AW, 4, address width; DEPTH = 2**AW = 16 words.

Ports:
- clk  input  1  single clock; all registers on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  run request, sampled only in IDLE or DONE.
- seed  input  DW  pattern seed, latched when start is accepted.
- busy  output  1  high while a run is in progress.
- done  output  1  level, high after run completes until next accepted start.
- pass  output  1  valid when done=1; 1 iff err_cnt==0.
- err_cnt  output  AW+2  mismatch count for the run (max 2*DEPTH, never wraps).
- first_err_addr  output  AW  address of first mismatch.
- first_err_exp  output  DW  expected data at first mismatch.
- first_err_act  output  DW  actual data at first mismatch.
- first_err_phase  output  1  phase (0/1) of first mismatch.
- ram_wr  output  1  RAM write enable (1=write, 0=read).
- ram_addr  output  AW  RAM address.
- ram_din  output  DW  RAM write data.
- ram_dout  input  DW  RAM registered read data (valid the cycle after a read-issue cycle).

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0, including ram_wr, ram_addr and ram_din. Diagnostics cleared. RAM contents are not touched.
- All outputs are registered.
- States: IDLE -> WRITE -> READ -> DRAIN -> (phase 0: WRITE of phase 1 | phase 1: DONE). DONE -> WRITE on start.
- Accepting start (IDLE or DONE, start=1):
  - latch seed, phase=0, clear done/pass/err_cnt/first_err_*.
  - busy=1; enter WRITE with ram_addr=0.
- Pattern: P(a) = a zero-extended to DW, XOR seed. Phase 0 writes/expects P(a); phase 1 writes/expects ~P(a).
- WRITE: DEPTH cycles, ram_wr=1, ram_addr=0..DEPTH-1, ram_din=pattern(addr), one address per cycle.
- READ: DEPTH cycles, ram_wr=0, ram_addr=0..DEPTH-1, ram_din=0.
- Compare pipeline: the address/expected value of each read-issue cycle is delayed one cycle. ram_dout is compared against it in the following cycle.
- DRAIN: one cycle, ram_wr=0, ram_addr held at DEPTH-1. It compares the last read. The redundant RAM read is harmless.
- Mismatch: err_cnt+1. If it is the first in the run, capture addr, expected, actual and phase.
- Latency: done=1 and busy=0 exactly 2*(2*DEPTH+1)=66 rising edges after the edge that accepted start. pass is valid on the same edge. Outputs then return to ram_wr=0, ram_addr=0, ram_din=0.
- start while busy: ignored; no restart, no effect on results.
- start held high continuously: a new run starts at every DONE entry, i.e. back-to-back runs. done pulses high for 1 cycle between runs.
- rst_n asserted mid-run: immediate abort to reset values. A subsequent start runs a full 66-cycle test.
- seed changes during a run: no effect.

Test Plan:
- Fault-free RAM model, seed=0x00, start pulse -> ram_wr=1 with addr 0..15 / din 0x00..0x0F, then reads, then din 0xFF..0xF0. done=1 66 edges after start; pass=1; err_cnt=0.
- seed=0xA5 -> phase-0 write at addr 3 carries 0xA6; phase-1 write at addr 3 carries 0x59; pass=1.
- RAM model with mem[5] bit0 stuck-at-0, seed=0x00 -> err_cnt=1, first_err_addr=5, exp=0x05, act=0x04, phase=0, pass=0.
- RAM model whose address 3 aliases to 2 (writes to 3 land in 2), seed=0x00 -> first mismatch addr=2, exp=0x02, act=0x03, phase 0. err_cnt=4 (addrs 2,3 in each phase).
- start held high through a run -> busy stays 1 with no restart. Next run begins immediately after done, with done high for 1 cycle.
- rst_n low for 2 cycles at edge 20 of a run -> busy=0, done=0, ram_wr=0 immediately. New start -> clean 66-cycle run with pass=1.
